pcie_rst_sequencer: RTL and testbench
=====================================

# pcie_rst_sequencer

Synthesizable reset sequencer for the CPM PCIe endpoint subsystem. Sequences release of PS power-on reset, CPM5 LPD power-on reset and per-controller PERST#, then supervises link-up with a timeout. It replaces ad-hoc fixed-delay reset release with a single ordered, restartable controller clocked from the PCIe reference clock domain.

## Interface
- POR_HOLD_CYCLES, 500: cycles all resets stay asserted after `sys_rst_n` release; must be ≥1.
- PERST_DELAY_CYCLES, 100: cycles between POR release and PERST# release; must be ≥1.
- LINKUP_TIMEOUT_CYCLES, 1_000_000: cycles allowed in link wait before failure; must be ≥1.
- NUM_PERST, 2: number of PERST# outputs (controllers 0..NUM_PERST-1).
- CNT_W, 24: counter width; elaboration error if any cycle parameter exceeds 2^CNT_W.

Ports:
- sys_clk  in  1  reference clock; single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- restart_i  in  1  one-cycle pulse; re-runs the full sequence from any state.
- link_up_i  in  1  link-up status, asynchronous to sys_clk.
- por_n_o  out  1  PS POR, active-low.
- cpm_por_n_o  out  1  CPM5 LPD POR, active-low.
- perst_n_o  out  NUM_PERST  PERST# per controller, active-low; all bits move together.
- done_o  out  1  high while link is up in state UP.
- timeout_o  out  1  high in state FAIL.
- state_o  out  3  current state encoding.

## Operation
- States: HOLD=0, POR_REL=1, LINK_WAIT=2, UP=3, FAIL=4. Encodings 5–7 are unreachable and decode to HOLD.
- One counter `cnt` (CNT_W bits), cleared on every state entry and incremented each cycle in HOLD, POR_REL and LINK_WAIT.
- HOLD: all resets asserted. When `cnt == POR_HOLD_CYCLES-1`, go to POR_REL.
- POR_REL: por_n_o=1 and cpm_por_n_o=1; perst_n_o=0. When `cnt == PERST_DELAY_CYCLES-1`, go to LINK_WAIT.
- LINK_WAIT: all resets released. If link_up_s=1, go to UP. Otherwise, when `cnt == LINKUP_TIMEOUT_CYCLES-1`, go to FAIL.
- UP: done_o=1. If link_up_s=0, go to LINK_WAIT (counter cleared, PERST# stays released).
- FAIL: timeout_o=1, resets remain released; the block waits for restart_i.
- restart_i=1 in any state → HOLD next edge, counter cleared, all resets reasserted.
- Priority: restart_i > link_up_s > timeout terminal count.
- link_up_s is link_up_i passed through a 2-flop synchronizer.

## Timing
- On reset assertion, outputs take these values asynchronously: por_n_o=0, cpm_por_n_o=0, perst_n_o=0, done_o=0, timeout_o=0, state_o=0 (HOLD), cnt=0.
- All outputs are registered and change on the same edge as the state.
- Edge 1 is the first sys_clk rising edge after sys_rst_n deasserts.
  - por_n_o and cpm_por_n_o rise at edge POR_HOLD_CYCLES.
  - perst_n_o rises at edge POR_HOLD_CYCLES+PERST_DELAY_CYCLES.
- Link latency: done_o rises 3 edges after link_up_i rises (2 synchronizer edges + 1 FSM edge). done_o falls 3 edges after link_up_i falls.
- timeout_o rises exactly LINKUP_TIMEOUT_CYCLES edges after LINK_WAIT entry if link_up_s never asserts.
- restart_i sampled high → state_o=0 and all resets asserted at that same edge's update. The following HOLD phase again lasts POR_HOLD_CYCLES.
- Reset asserted mid-sequence: immediate return to HOLD values; no partial-release glitch on any output.

## Structure
- Package `pcie_rst_seq_pkg`: state enum and its 3-bit encodings; the `LINK_SYNC_STAGES=2` constant.
- Sub-module `pcie_rst_sync_2ff`: 2-flop synchronizer for link_up_i, reset to 0 by sys_rst_n.
- The FSM and counter stay in the top module.

## Test plan
Bench parameters: POR_HOLD=8, PERST_DELAY=4, TIMEOUT=16, NUM_PERST=2.
- Reset release, link_up_i held 0: por_n_o rises at edge 8, perst_n_o=2'b11 at edge 12, timeout_o=1 and state_o=4 at edge 28.
- link_up_i raised 5 cycles after perst_n_o release: done_o=1 and state_o=3 exactly 3 edges later; timeout_o stays 0.
- In UP, link_up_i dropped for 10 cycles then restored: done_o falls after 3 edges, state_o=2, perst_n_o stays 2'b11, done_o returns with no timeout.
- restart_i pulsed in FAIL, and separately in UP: next edge state_o=0, all resets 0. Full 8/4 sequence repeats.
- sys_rst_n asserted during POR_REL: outputs return immediately and asynchronously to reset values. After release, timing matches the first scenario.
- restart_i and link_up_s both high in LINK_WAIT on the terminal-count cycle: state_o=0 (restart wins). Separately, link_up_s high on the terminal cycle without restart: state_o=3, not 4.

Source files
------------

// File: rtl/pcie_rst_seq_pkg.sv
// pcie_rst_seq_pkg: shared state encodings and constants for the PCIe reset sequencer
package pcie_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_POR_REL   = 3'd1,
        S_LINK_WAIT = 3'd2,
        S_UP        = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    localparam int unsigned LINK_SYNC_STAGES = 2;

endpackage

// File: rtl/pcie_rst_sync_2ff.sv
// pcie_rst_sync_2ff: multi-flop synchronizer for the asynchronous link-up status
module pcie_rst_sync_2ff
    import pcie_rst_seq_pkg::*;
#(
    parameter int unsigned STAGES = LINK_SYNC_STAGES
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ff <= '0;
        else            ff <= {ff[STAGES-2:0], d_i};
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/pcie_rst_sequencer.sv
// pcie_rst_sequencer: ordered POR / PERST# release with supervised, restartable link-up
module pcie_rst_sequencer
    import pcie_rst_seq_pkg::*;
#(
    parameter int unsigned POR_HOLD_CYCLES       = 500,
    parameter int unsigned PERST_DELAY_CYCLES    = 100,
    parameter int unsigned LINKUP_TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned NUM_PERST             = 2,
    parameter int unsigned CNT_W                 = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 restart_i,
    input  logic                 link_up_i,
    output logic                 por_n_o,
    output logic                 cpm_por_n_o,
    output logic [NUM_PERST-1:0] perst_n_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [2:0]           state_o
);

    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

    if (POR_HOLD_CYCLES < 1 || PERST_DELAY_CYCLES < 1 || LINKUP_TIMEOUT_CYCLES < 1) begin : g_min_err
        $error("pcie_rst_sequencer: cycle parameters must be >= 1");
    end
    if (longint'(POR_HOLD_CYCLES) > CNT_SPAN || longint'(PERST_DELAY_CYCLES) > CNT_SPAN ||
        longint'(LINKUP_TIMEOUT_CYCLES) > CNT_SPAN) begin : g_width_err
        $error("pcie_rst_sequencer: cycle parameter exceeds 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(POR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_TC  = CNT_W'(PERST_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] LINK_TC = CNT_W'(LINKUP_TIMEOUT_CYCLES - 1);

    logic             link_up_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    state_e           state;
    state_e           nxt;
    logic             counting;

    pcie_rst_sync_2ff u_link_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d_i       (link_up_i),
        .q_o       (link_up_s)
    );

    // restart overrides everything; link-up outranks the timeout terminal count
    always_comb begin
        nxt = S_HOLD;
        case (state)
            S_HOLD:      nxt = (cnt == HOLD_TC) ? S_POR_REL : S_HOLD;
            S_POR_REL:   nxt = (cnt == REL_TC) ? S_LINK_WAIT : S_POR_REL;
            S_LINK_WAIT: nxt = link_up_s ? S_UP : (cnt == LINK_TC) ? S_FAIL : S_LINK_WAIT;
            S_UP:        nxt = link_up_s ? S_UP : S_LINK_WAIT;
            S_FAIL:      nxt = S_FAIL;
            default:     nxt = S_HOLD;
        endcase
        if (restart_i) nxt = S_HOLD;
    end

    assign counting = (state == S_HOLD) || (state == S_POR_REL) || (state == S_LINK_WAIT);
    assign cnt_nxt  = (restart_i || nxt != state) ? '0 : counting ? cnt + 1'b1 : cnt;

    // outputs are decoded from the next state so they move on the same edge as state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_HOLD;
            cnt         <= '0;
            por_n_o     <= 1'b0;
            cpm_por_n_o <= 1'b0;
            perst_n_o   <= '0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= cnt_nxt;
            por_n_o     <= nxt != S_HOLD;
            cpm_por_n_o <= nxt != S_HOLD;
            perst_n_o   <= {NUM_PERST{nxt == S_LINK_WAIT || nxt == S_UP || nxt == S_FAIL}};
            done_o      <= nxt == S_UP;
            timeout_o   <= nxt == S_FAIL;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pcie_rst_sequencer.sv
// tb_pcie_rst_sequencer: directed self-checking bench for the PCIe reset sequencer
module tb_pcie_rst_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       restart_i = 1'b0;
    logic       link_up_i = 1'b0;
    logic       por_n_o;
    logic       cpm_por_n_o;
    logic [1:0] perst_n_o;
    logic       done_o;
    logic       timeout_o;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    pcie_rst_sequencer #(
        .POR_HOLD_CYCLES       (8),
        .PERST_DELAY_CYCLES    (4),
        .LINKUP_TIMEOUT_CYCLES (16),
        .NUM_PERST             (2),
        .CNT_W                 (24)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .restart_i   (restart_i),
        .link_up_i   (link_up_i),
        .por_n_o     (por_n_o),
        .cpm_por_n_o (cpm_por_n_o),
        .perst_n_o   (perst_n_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_state"}, 32'(state_o), 0);
        check({tag, "_por"}, 32'(por_n_o), 0);
        check({tag, "_cpm"}, 32'(cpm_por_n_o), 0);
        check({tag, "_perst"}, 32'(perst_n_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_tmo"}, 32'(timeout_o), 0);
    endtask

    // edge 1 is the first rising edge after the call returns
    task automatic release_rst();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic por_perst_timing(input string tag);
        tick(7);
        check({tag, "_e7_por"}, 32'(por_n_o), 0);
        check({tag, "_e7_state"}, 32'(state_o), 0);
        tick(1);
        check({tag, "_e8_por"}, 32'(por_n_o), 1);
        check({tag, "_e8_cpm"}, 32'(cpm_por_n_o), 1);
        check({tag, "_e8_perst"}, 32'(perst_n_o), 0);
        check({tag, "_e8_state"}, 32'(state_o), 1);
        tick(3);
        check({tag, "_e11_perst"}, 32'(perst_n_o), 0);
        tick(1);
        check({tag, "_e12_perst"}, 32'(perst_n_o), 3);
        check({tag, "_e12_state"}, 32'(state_o), 2);
    endtask

    initial begin
        #1 sys_rst_n = 1'b0;
        #1 check_all_reset("rst");
        release_rst();
        por_perst_timing("seq1");
        tick(15);
        check("e27_state", 32'(state_o), 2);
        check("e27_tmo", 32'(timeout_o), 0);
        tick(1);
        check("e28_state", 32'(state_o), 4);
        check("e28_tmo", 32'(timeout_o), 1);
        check("e28_perst", 32'(perst_n_o), 3);
        check("e28_por", 32'(por_n_o), 1);

        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        check_all_reset("rs_fail");
        por_perst_timing("seq2");

        tick(5);
        link_up_i = 1'b1;
        tick(2);
        check("lu_e2_done", 32'(done_o), 0);
        check("lu_e2_state", 32'(state_o), 2);
        tick(1);
        check("lu_e3_done", 32'(done_o), 1);
        check("lu_e3_state", 32'(state_o), 3);
        check("lu_e3_tmo", 32'(timeout_o), 0);

        link_up_i = 1'b0;
        tick(2);
        check("ld_e2_done", 32'(done_o), 1);
        tick(1);
        check("ld_e3_done", 32'(done_o), 0);
        check("ld_e3_state", 32'(state_o), 2);
        check("ld_e3_perst", 32'(perst_n_o), 3);
        tick(7);
        check("ld_e10_state", 32'(state_o), 2);
        link_up_i = 1'b1;
        tick(3);
        check("lr_done", 32'(done_o), 1);
        check("lr_state", 32'(state_o), 3);
        check("lr_tmo", 32'(timeout_o), 0);

        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        check_all_reset("rs_up");
        por_perst_timing("seq3");
        check("seq3_e12_done", 32'(done_o), 0);
        tick(1);
        check("seq3_e13_state", 32'(state_o), 3);
        check("seq3_e13_done", 32'(done_o), 1);

        link_up_i = 1'b0;
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        tick(10);
        check("mid_state", 32'(state_o), 1);
        #2 sys_rst_n = 1'b0;
        #1 check_all_reset("async");
        tick(2);
        check_all_reset("async_hold");
        release_rst();
        por_perst_timing("seq4");

        tick(13);
        link_up_i = 1'b1;
        tick(2);
        check("pri_e27_state", 32'(state_o), 2);
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        check("pri_rs_state", 32'(state_o), 0);
        check("pri_rs_por", 32'(por_n_o), 0);

        link_up_i = 1'b0;
        tick(8);
        check("seq5_e8_state", 32'(state_o), 1);
        tick(4);
        check("seq5_e12_state", 32'(state_o), 2);
        tick(13);
        link_up_i = 1'b1;
        tick(2);
        check("pri_lu_e27_state", 32'(state_o), 2);
        tick(1);
        check("pri_lu_state", 32'(state_o), 3);
        check("pri_lu_tmo", 32'(timeout_o), 0);
        check("pri_lu_done", 32'(done_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
